// File: rtl/ahb_ram_bist_master.sv
// AHB-lite BIST master: writes seed+i over a word range in INCR bursts, reads it back and compares.
// Latency: 2*N+2 cycles from start to done with zero wait states, plus one cycle per wait state.
// Backpressure: every output is held while hready_m=0; an ERROR response aborts the test.
module ahb_ram_bist_master (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        start,
    input  logic [19:0] base_addr,
    input  logic [17:0] word_cnt,
    input  logic [31:0] seed,
    output logic [19:0] haddr_m,
    output logic [1:0]  htrans_m,
    output logic [2:0]  hburst_m,
    output logic        hwrite_m,
    output logic [31:0] hwdata_m,
    input  logic [31:0] hrdata_m,
    input  logic        hready_m,
    input  logic [1:0]  hresp_m,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [19:0] first_fail_addr,
    output logic        bus_err
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NSEQ   = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_LAST, S_ABORT} state_t;

    state_t      state_q, state_d;
    logic [19:0] base_q, base_d;
    logic [17:0] cnt_q, cnt_d;
    logic [31:0] seed_q, seed_d;
    logic [17:0] idx_q, idx_d;
    logic        dph_vld_q, dph_vld_d;
    logic        dph_wr_q, dph_wr_d;
    logic [31:0] dph_exp_q, dph_exp_d;
    logic [19:0] dph_addr_q, dph_addr_d;

    logic [19:0] haddr_d;
    logic [1:0]  htrans_d;
    logic [2:0]  hburst_d;
    logic        hwrite_d;
    logic [31:0] hwdata_d;
    logic        busy_d, done_d, pass_d, bus_err_d;
    logic [15:0] err_cnt_d;
    logic [19:0] ffa_d;

    logic [19:0] addr_nxt;
    logic        last_beat;
    logic        err_first;
    logic        rd_cmp;
    logic [31:0] beat_dat;

    assign addr_nxt  = haddr_m + 20'd4;
    assign last_beat = (idx_q == cnt_q - 18'd1);
    assign err_first = (hresp_m == RESP_ERR) && !hready_m;
    assign rd_cmp    = dph_vld_q && !dph_wr_q && hready_m && (hresp_m == RESP_OKAY);
    assign beat_dat  = seed_q + {14'd0, idx_q};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        seed_d     = seed_q;
        idx_d      = idx_q;
        dph_vld_d  = dph_vld_q;
        dph_wr_d   = dph_wr_q;
        dph_exp_d  = dph_exp_q;
        dph_addr_d = dph_addr_q;
        haddr_d    = haddr_m;
        htrans_d   = htrans_m;
        hburst_d   = hburst_m;
        hwrite_d   = hwrite_m;
        hwdata_d   = hwdata_m;
        busy_d     = busy;
        done_d     = 1'b0;
        pass_d     = pass;
        bus_err_d  = bus_err;
        err_cnt_d  = err_cnt;
        ffa_d      = first_fail_addr;

        if (rd_cmp && (hrdata_m != dph_exp_q)) begin
            if (err_cnt == 16'd0) ffa_d = dph_addr_q;
            if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
        end

        // An accepted address phase becomes the data phase of the next cycle.
        if (hready_m) begin
            dph_vld_d  = (htrans_m != TR_IDLE);
            dph_wr_d   = hwrite_m;
            dph_addr_d = haddr_m;
            dph_exp_d  = beat_dat;
            if ((htrans_m != TR_IDLE) && hwrite_m) hwdata_d = beat_dat;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_addr & 20'hFFFFC;
                    cnt_d     = word_cnt;
                    seed_d    = seed;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    ffa_d     = '0;
                    pass_d    = 1'b0;
                    bus_err_d = 1'b0;
                    if (word_cnt == 18'd0) begin
                        done_d = 1'b1;
                        pass_d = 1'b1;
                    end else begin
                        busy_d   = 1'b1;
                        state_d  = S_WR;
                        haddr_d  = base_addr & 20'hFFFFC;
                        htrans_d = TR_NSEQ;
                        hburst_d = BU_INCR;
                        hwrite_d = 1'b1;
                    end
                end
            end
            S_WR, S_RD: begin
                if (err_first) begin
                    state_d   = S_ABORT;
                    htrans_d  = TR_IDLE;
                    hburst_d  = BU_SINGLE;
                    hwrite_d  = 1'b0;
                    dph_vld_d = 1'b0;
                end else if (hready_m) begin
                    if (last_beat) begin
                        idx_d    = '0;
                        hwrite_d = 1'b0;
                        if (state_q == S_WR) begin
                            state_d  = S_RD;
                            haddr_d  = base_q;
                            htrans_d = TR_NSEQ;
                        end else begin
                            state_d  = S_RD_LAST;
                            htrans_d = TR_IDLE;
                            hburst_d = BU_SINGLE;
                        end
                    end else begin
                        idx_d    = idx_q + 18'd1;
                        haddr_d  = addr_nxt;
                        // A burst may not cross a 1 KB boundary, so restart it there.
                        htrans_d = (addr_nxt[9:0] == 10'd0) ? TR_NSEQ : TR_SEQ;
                    end
                end
            end
            S_RD_LAST: begin
                if (err_first) begin
                    state_d   = S_ABORT;
                    dph_vld_d = 1'b0;
                end else if (hready_m) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_d == 16'd0);
                end
            end
            S_ABORT: begin
                if (hready_m) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    bus_err_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            cnt_q           <= '0;
            seed_q          <= '0;
            idx_q           <= '0;
            dph_vld_q       <= 1'b0;
            dph_wr_q        <= 1'b0;
            dph_exp_q       <= '0;
            dph_addr_q      <= '0;
            haddr_m         <= '0;
            htrans_m        <= TR_IDLE;
            hburst_m        <= BU_SINGLE;
            hwrite_m        <= 1'b0;
            hwdata_m        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            bus_err         <= 1'b0;
            err_cnt         <= '0;
            first_fail_addr <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            seed_q          <= seed_d;
            idx_q           <= idx_d;
            dph_vld_q       <= dph_vld_d;
            dph_wr_q        <= dph_wr_d;
            dph_exp_q       <= dph_exp_d;
            dph_addr_q      <= dph_addr_d;
            haddr_m         <= haddr_d;
            htrans_m        <= htrans_d;
            hburst_m        <= hburst_d;
            hwrite_m        <= hwrite_d;
            hwdata_m        <= hwdata_d;
            busy            <= busy_d;
            done            <= done_d;
            pass            <= pass_d;
            bus_err         <= bus_err_d;
            err_cnt         <= err_cnt_d;
            first_fail_addr <= ffa_d;
        end
    end

endmodule

// File: tb/tb_ahb_ram_bist_master.sv
// Bench for ahb_ram_bist_master: an AHB RAM slave model with wait/error/corruption injection,
// a transaction-level expected-beat queue checked every cycle, and per-run result checks.
module tb_ahb_ram_bist_master;
    logic        hclk = 1'b0;
    logic        hresetn;
    logic        start;
    logic [19:0] base_addr;
    logic [17:0] word_cnt;
    logic [31:0] seed;
    logic [19:0] haddr_m;
    logic [1:0]  htrans_m;
    logic [2:0]  hburst_m;
    logic        hwrite_m;
    logic [31:0] hwdata_m;
    logic [31:0] hrdata_m;
    logic        hready_m;
    logic [1:0]  hresp_m;
    logic        busy, done, pass, bus_err;
    logic [15:0] err_cnt;
    logic [19:0] first_fail_addr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [19:0] addr;
        logic [1:0]  trans;
        logic        wr;
        int          idx;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem [logic [19:0]];
    bit          corrupt [logic [19:0]];
    logic [31:0] run_seed = 32'h0;
    bit          cfg_wait = 1'b0;
    int          cfg_err_beat = -1;
    bit          no_more = 1'b0;
    int          err_ph = 0;
    int          beat_no = 0;

    ahb_ram_bist_master dut (
        .hclk(hclk), .hresetn(hresetn), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .seed(seed), .haddr_m(haddr_m), .htrans_m(htrans_m),
        .hburst_m(hburst_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m), .hrdata_m(hrdata_m),
        .hready_m(hready_m), .hresp_m(hresp_m), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail_addr(first_fail_addr), .bus_err(bus_err)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_haddr"}, 32'(haddr_m), 32'h0);
        chk({tag, "_htrans"}, 32'(htrans_m), 32'h0);
        chk({tag, "_hburst"}, 32'(hburst_m), 32'h0);
        chk({tag, "_hwrite"}, 32'(hwrite_m), 32'h0);
        chk({tag, "_hwdata"}, hwdata_m, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
        chk({tag, "_ffa"}, 32'(first_fail_addr), 32'h0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    endtask

    // Slave model plus per-cycle bus checker; everything happens at the falling edge.
    initial begin
        logic        dp_vld;
        logic        dp_wr;
        logic [19:0] dp_addr;
        int          dp_idx;
        int          wait_left;
        beat_t       head;
        hready_m = 1'b1; hresp_m = 2'b00; hrdata_m = 32'h0;
        dp_vld = 1'b0; dp_wr = 1'b0; dp_addr = '0; dp_idx = 0; wait_left = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                dp_vld = 1'b0; wait_left = 0;
                hready_m = 1'b1; hresp_m = 2'b00; hrdata_m = 32'h0;
            end else begin
                hready_m = 1'b1; hresp_m = 2'b00; hrdata_m = 32'h0;
                if (dp_vld) begin
                    if (dp_wr && dp_idx == cfg_err_beat) begin
                        hresp_m = 2'b01;
                        if (err_ph == 0) begin
                            hready_m = 1'b0;
                            err_ph = 1;
                        end
                    end else if (wait_left > 0) begin
                        hready_m = 1'b0;
                        wait_left--;
                    end
                    if (dp_wr)
                        chk("hwdata", hwdata_m, run_seed + 32'(dp_idx));
                    else if (corrupt.exists(dp_addr))
                        hrdata_m = 32'h0;
                    else if (mem.exists(dp_addr))
                        hrdata_m = mem[dp_addr];
                end
                if (htrans_m != 2'b00) begin
                    if (no_more || exp_q.size() == 0) begin
                        chk("extra_xfer_htrans", 32'(htrans_m), 32'h0);
                    end else begin
                        head = exp_q[0];
                        chk("haddr", 32'(haddr_m), 32'(head.addr));
                        chk("htrans", 32'(htrans_m), 32'(head.trans));
                        chk("hwrite", 32'(hwrite_m), 32'(head.wr));
                        chk("hburst", 32'(hburst_m), 32'h1);
                    end
                end else begin
                    chk("hburst_idle", 32'(hburst_m), 32'h0);
                end
                if (hresp_m == 2'b01 && !hready_m) no_more = 1'b1;
                if (hready_m) begin
                    if (dp_vld && dp_wr && hresp_m == 2'b00) mem[dp_addr] = hwdata_m;
                    dp_vld = 1'b0;
                    if (htrans_m != 2'b00 && exp_q.size() > 0 && !no_more) begin
                        head = exp_q.pop_front();
                        dp_vld = 1'b1; dp_wr = head.wr; dp_addr = head.addr; dp_idx = head.idx;
                        beat_no++;
                        wait_left = (cfg_wait && (beat_no % 3 == 0)) ? 2 : 0;
                    end
                end
            end
        end
    end

    task automatic run(input string tag, input logic [19:0] b, input logic [17:0] n,
                       input logic [31:0] s, input int exp_done, input int probe_k,
                       input logic [19:0] probe_a, input logic [1:0] probe_t,
                       input int repulse_k, input int rst_k);
        int          k;
        int          nn;
        int          exp_err;
        logic [19:0] exp_ffa;
        logic [19:0] a;
        logic [19:0] b_al;
        logic [31:0] rd;
        bit          exp_bus;
        @(negedge hclk);
        nn = int'(n);
        b_al = b & 20'hFFFFC;
        exp_q.delete();
        no_more = 1'b0; err_ph = 0; beat_no = 0; run_seed = s;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < nn; i++) begin
                a = b_al + 20'(4 * i);
                exp_q.push_back('{a, (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11, (p == 0), i});
            end
        end
        exp_bus = (cfg_err_beat >= 0) && (cfg_err_beat < nn);
        exp_err = 0; exp_ffa = '0;
        if (!exp_bus) begin
            for (int i = 0; i < nn; i++) begin
                a = b_al + 20'(4 * i);
                rd = corrupt.exists(a) ? 32'h0 : s + 32'(i);
                if (rd != s + 32'(i)) begin
                    if (exp_err == 0) exp_ffa = a;
                    if (exp_err < 65535) exp_err++;
                end
            end
        end
        base_addr = b; word_cnt = n; seed = s; start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 200) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'h1);
            if (k == probe_k) begin
                chk({tag, "_probe_htrans"}, 32'(htrans_m), 32'(probe_t));
                if (probe_t != 2'b00) chk({tag, "_probe_haddr"}, 32'(haddr_m), 32'(probe_a));
            end
            if (k == repulse_k) begin
                start = 1'b1; base_addr = 20'h5555C; seed = 32'hDEAD0000; word_cnt = 18'd7;
            end
            if (k == rst_k) begin
                hresetn = 1'b0;
                #1;
                check_reset({tag, "_mid"});
                break;
            end
            @(negedge hclk);
            start = 1'b0;
            k++;
        end
        if (rst_k > 0) begin
            @(negedge hclk);
            chk({tag, "_held_done"}, 32'(done), 32'h0);
            hresetn = 1'b1;
            @(negedge hclk);
            chk({tag, "_after_busy"}, 32'(busy), 32'h0);
            chk({tag, "_after_htrans"}, 32'(htrans_m), 32'h0);
        end else begin
            chk({tag, "_done_cycle"}, 32'(k), 32'(exp_done));
            chk({tag, "_busy_done"}, 32'(busy), 32'h0);
            chk({tag, "_pass"}, 32'(pass), 32'((exp_err == 0) && !exp_bus));
            chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
            chk({tag, "_ffa"}, 32'(first_fail_addr), 32'(exp_ffa));
            chk({tag, "_bus_err"}, 32'(bus_err), 32'(exp_bus));
            @(negedge hclk);
            chk({tag, "_done_pulse"}, 32'(done), 32'h0);
            chk({tag, "_pass_hold"}, 32'(pass), 32'((exp_err == 0) && !exp_bus));
        end
    endtask

    initial begin
        hresetn = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; seed = '0;
        repeat (3) @(negedge hclk);
        check_reset("por");
        hresetn = 1'b1;

        run("zw", 20'h00100, 18'd4, 32'hA5A50000, 10, 5, 20'h00100, 2'b10, 0, 0);
        chk("zw_pass_lit", 32'(pass), 32'h1);
        chk("zw_mem_lit", mem.exists(20'h0010C) ? mem[20'h0010C] : 32'h0, 32'hA5A50003);

        cfg_wait = 1'b1;
        run("ws", 20'h00100, 18'd4, 32'hA5A50000, 14, 0, 20'h0, 2'b00, 0, 0);
        cfg_wait = 1'b0;

        corrupt[20'h00108] = 1'b1;
        corrupt[20'h0010C] = 1'b1;
        run("cor", 20'h00100, 18'd4, 32'hA5A50000, 10, 0, 20'h0, 2'b00, 0, 0);
        corrupt.delete();
        chk("cor_err_lit", 32'(err_cnt), 32'd2);
        chk("cor_ffa_lit", 32'(first_fail_addr), 32'h00108);
        chk("cor_pass_lit", 32'(pass), 32'h0);

        run("bnd", 20'h003F8, 18'd4, 32'h11110000, 10, 3, 20'h00400, 2'b10, 0, 0);
        run("bnd_rd", 20'h003F8, 18'd4, 32'h11110000, 10, 7, 20'h00400, 2'b10, 0, 0);
        run("wrap", 20'hFFFFC, 18'd2, 32'h22220000, 6, 2, 20'h00000, 2'b10, 0, 0);

        cfg_err_beat = 2;
        run("berr", 20'h00100, 18'd4, 32'h33330000, 6, 5, 20'h0, 2'b00, 0, 0);
        cfg_err_beat = -1;
        chk("berr_bus_err_lit", 32'(bus_err), 32'h1);
        chk("berr_pass_lit", 32'(pass), 32'h0);

        run("rep", 20'h00100, 18'd4, 32'hA5A50000, 10, 0, 20'h0, 2'b00, 3, 0);
        run("rst", 20'h00200, 18'd4, 32'h12340000, 0, 0, 20'h0, 2'b00, 0, 6);
        run("zero", 20'h00100, 18'd0, 32'h0, 1, 0, 20'h0, 2'b00, 0, 0);
        chk("zero_pass_lit", 32'(pass), 32'h1);

        repeat (2) @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
